// File: rtl/seq_mul_pkg.sv
// rtl/seq_mul_pkg.sv - shared types and helpers for the sequential shift-and-add multiplier
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Counter must hold the value WIDTH itself, not just WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_mul_n.sv
// rtl/seq_mul_n.sv - parametrised signed/unsigned shift-and-add multiplier with busy/done handshake
// Optional early termination on a zero multiplier is enabled by SEQ_MUL_EARLY_EXIT_EN.
module seq_mul_n
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ld,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   y,
    output logic                 busy,
    output logic                 done
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam int PW    = 2 * WIDTH;

    state_t             state;
    logic [PW-1:0]      ra;
    logic [PW-1:0]      acc;
    logic [WIDTH-1:0]   rb;
    logic [CNT_W-1:0]   cnt;
    logic               neg;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               fin;

    // The most negative value negates to itself, which read unsigned is the correct magnitude.
    assign mag_a = (sgn && a[WIDTH-1]) ? -a : a;
    assign mag_b = (sgn && b[WIDTH-1]) ? -b : b;

`ifdef SEQ_MUL_EARLY_EXIT_EN
    // Finish once the multiplier is exhausted, but only after at least one iteration.
    assign fin = (cnt == '0) || ((rb == '0) && (cnt != CNT_W'(WIDTH)));
`else
    assign fin = (cnt == '0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ra    <= '0;
            acc   <= '0;
            rb    <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            y     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (ld) begin
                        ra    <= {{WIDTH{1'b0}}, mag_a};
                        rb    <= mag_b;
                        neg   <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc   <= '0;
                        cnt   <= CNT_W'(WIDTH);
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        state <= CALC;
                    end else begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                CALC: begin
                    if (fin) begin
                        y     <= neg ? -acc : acc;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        if (rb[0]) begin
                            acc <= acc + ra;
                        end
                        ra  <= ra << 1;
                        rb  <= rb >> 1;
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul_n.sv
// tb/tb_seq_mul_n.sv - self-checking bench for seq_mul_n at WIDTH=4 and WIDTH=8
module tb_seq_mul_n;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld4, ld8, sgn;
    logic [7:0]  a, b;
    logic [7:0]  y4;
    logic [15:0] y8;
    logic        busy4, done4, busy8, done8;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] last_y4 = '0;
    logic [15:0] last_y8 = '0;

    seq_mul_n #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .ld(ld4), .sgn(sgn), .a(a[3:0]), .b(b[3:0]),
        .y(y4), .busy(busy4), .done(done4)
    );

    seq_mul_n #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .ld(ld8), .sgn(sgn), .a(a), .b(b),
        .y(y8), .busy(busy8), .done(done8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_prod(input int w, input bit s,
                                             input logic [7:0] av, input logic [7:0] bv);
        longint x, z, p, m;
        m = (longint'(1) << w) - 1;
        x = longint'(av) & m;
        z = longint'(bv) & m;
        if (s && x[w-1]) x = x - (longint'(1) << w);
        if (s && z[w-1]) z = z - (longint'(1) << w);
        p = (x * z) & ((longint'(1) << (2 * w)) - 1);
        return p[15:0];
    endfunction

    function automatic int ref_lat(input int w, input bit s, input logic [7:0] bv);
`ifdef SEQ_MUL_EARLY_EXIT_EN
        int mag, h;
        mag = int'(bv) & ((1 << w) - 1);
        if (s && mag[w-1]) mag = (1 << w) - mag;
        if (mag == 0) return 2;
        h = 0;
        for (int i = 0; i < w; i++) if (mag[i]) h = i;
        return h + 2;
`else
        return w + 1;
`endif
    endfunction

    task automatic issue(input int w, input bit s, input logic [7:0] av, input logic [7:0] bv);
        sgn = s; a = av; b = bv;
        if (w == 4) ld4 = 1'b1; else ld8 = 1'b1;
        @(posedge clk); #1;
        ld4 = 1'b0; ld8 = 1'b0;
    endtask

    task automatic finish_op(input int w, input int lat, input logic [15:0] yexp, input int glitch);
        logic [15:0] yo;
        logic        bz, dn;
        bit          seen;
        seen = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(posedge clk); #1;
            yo = (w == 4) ? {8'h00, y4} : y8;
            bz = (w == 4) ? busy4 : busy8;
            dn = (w == 4) ? done4 : done8;
            if (dn) begin
                seen = 1;
                chk($sformatf("w%0d latency", w), c, lat);
                chk($sformatf("w%0d product", w), yo, yexp);
                chk($sformatf("w%0d busy_at_done", w), bz, 0);
            end else begin
                chk($sformatf("w%0d y_held", w), yo, (w == 4) ? last_y4 : last_y8);
                chk($sformatf("w%0d busy_in_calc", w), bz, 1);
            end
            // A load strobe inside CALC must be ignored.
            if (c == glitch && !seen) begin
                a = 8'($urandom); b = 8'($urandom); sgn = 1'($urandom);
                if (w == 4) ld4 = 1'b1; else ld8 = 1'b1;
            end else begin
                ld4 = 1'b0; ld8 = 1'b0;
            end
        end
        if (!seen) chk($sformatf("w%0d done_timeout", w), 0, 1);
        if (w == 4) last_y4 = yexp; else last_y8 = yexp;
    endtask

    task automatic run(input int w, input bit s, input logic [7:0] av, input logic [7:0] bv,
                       input logic [15:0] yexp, input int glitch);
        issue(w, s, av, bv);
        finish_op(w, ref_lat(w, s, bv), yexp, glitch);
    endtask

    task automatic idle_check(input int w);
        @(posedge clk); #1;
        chk($sformatf("w%0d done_one_pulse", w), (w == 4) ? done4 : done8, 0);
    endtask

    initial begin
        logic [7:0]  ra_v, rb_v;
        bit          rs;
        int          rw;

        rst = 1'b0; ld4 = 1'b0; ld8 = 1'b0; sgn = 1'b0; a = '0; b = '0;
        #12;
        chk("reset y4", y4, 0);
        chk("reset busy4", busy4, 0);
        chk("reset done4", done4, 0);
        chk("reset y8", y8, 0);
        chk("reset busy8", busy8, 0);
        chk("reset done8", done8, 0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        run(4, 0, 8'h0D, 8'h0B, 16'h008F, 0);
        run(4, 0, 8'h09, 8'h06, 16'h0036, 0);
        idle_check(4);
        run(4, 1, 8'h0D, 8'h05, 16'h00F1, 0);
        run(4, 1, 8'h08, 8'h08, 16'h0040, 0);
        run(4, 0, 8'h0F, 8'h0F, 16'h00E1, 0);
        idle_check(4);
        run(4, 0, 8'h07, 8'h05, 16'h0023, 2);
        idle_check(4);

        run(8, 0, 8'h07, 8'h03, 16'd21, 0);
        run(8, 0, 8'h5A, 8'h00, 16'd0, 0);
        idle_check(8);
        run(8, 0, 8'hC3, 8'hFF, 16'hC23D, 2);
        run(8, 1, 8'h80, 8'h80, 16'h4000, 0);
        run(8, 1, 8'h80, 8'h7F, 16'hC080, 0);
        run(8, 1, 8'hFF, 8'hFF, 16'h0001, 0);
        idle_check(8);

        // Asynchronous reset two cycles into an operation.
        issue(8, 0, 8'hAB, 8'hCD);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("async_rst y8", y8, 0);
        chk("async_rst busy8", busy8, 0);
        chk("async_rst done8", done8, 0);
        chk("async_rst y4", y4, 0);
        last_y4 = '0; last_y8 = '0;
        @(negedge clk); @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("no_done_after_rst", done8, 0);
        end
        run(8, 0, 8'hAB, 8'hCD, ref_prod(8, 0, 8'hAB, 8'hCD), 0);

        for (int i = 0; i < 24; i++) begin
            rw   = ($urandom_range(0, 1) == 1) ? 8 : 4;
            rs   = 1'($urandom);
            ra_v = 8'($urandom);
            rb_v = 8'($urandom);
            if (i % 6 == 5) rb_v = 8'($urandom_range(0, 3));
            run(rw, rs, ra_v, rb_v, ref_prod(rw, rs, ra_v, rb_v), (i % 5 == 0) ? 1 : 0);
            if (i % 3 == 0) idle_check(rw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
